// File: rtl/sha3_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sha3_sponge_ctrl
// Brief   : SHA3-512 sponge sequencer. Packs RAM words into rate blocks,
//           applies pad10*1, drives the Keccak-f core and latches the digest.
// Revision: 1.0
// ============================================================================
module sha3_sponge_ctrl #(
  parameter int DIGIT  = 64,
  parameter int RATE   = 576,
  parameter int AW     = 10,
  parameter int DOUT_W = 512
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic [AW-1:0]     msg_words,
  output logic              mem_rd_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [DIGIT-1:0]  mem_rdata,
  output logic              blk_valid,
  output logic              blk_first,
  output logic [RATE-1:0]   blk_data,
  input  logic              blk_ready,
  input  logic              perm_done,
  input  logic [DOUT_W-1:0] state_out,
  output logic              busy,
  output logic              done,
  output logic [DOUT_W-1:0] dout
);

  localparam int c_WORDS = RATE / DIGIT;
  localparam int c_SW    = $clog2(c_WORDS + 1);
  localparam int c_GW    = AW + 1;
  localparam logic [DIGIT-1:0] c_PAD_HEAD = DIGIT'(8'h06);
  localparam logic [DIGIT-1:0] c_PAD_TAIL = {1'b1, {(DIGIT-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_OFFER = 3'd2,
    S_PERM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_msg;
  logic [c_GW-1:0]  r_base;      // global word index of slot 0 of the current block
  logic [c_SW-1:0]  r_slot;      // next slot to issue (read or pad)
  logic [c_SW-1:0]  r_rd_slot;
  logic             r_cap;
  logic [c_SW-1:0]  r_cap_slot;

  logic             w_issue;
  logic [c_SW-1:0]  w_slot;
  logic [c_GW-1:0]  w_base;
  logic [AW-1:0]    w_len;
  logic [c_GW-1:0]  w_gidx;
  logic             w_read;
  logic [DIGIT-1:0] w_pad;
  logic [c_GW-1:0]  w_next_base;
  logic             w_more;

  assign w_next_base = r_base + c_GW'(c_WORDS);
  assign w_more      = (w_next_base <= {1'b0, r_msg});

  // Slot 0 of each block is issued on the edge that enters FILL, so a full
  // block (9 issues + 2-cycle RAM pipeline) stays within 10 FILL cycles.
  always_comb begin
    w_issue = 1'b0;
    w_slot  = '0;
    w_base  = r_base;
    w_len   = r_msg;
    case (r_state)
      S_IDLE: begin
        w_issue = start;
        w_base  = '0;
        w_len   = msg_words;
      end
      S_FILL: begin
        w_issue = (r_slot != c_SW'(c_WORDS));
        w_slot  = r_slot;
      end
      S_PERM: begin
        w_issue = perm_done && w_more;
        w_base  = w_next_base;
      end
      default: ;
    endcase
  end

  assign w_gidx = w_base + c_GW'(w_slot);
  assign w_read = (w_gidx < {1'b0, w_len});

  always_comb begin
    w_pad = '0;
    if (w_gidx == {1'b0, w_len})
      w_pad = c_PAD_HEAD;
    if (w_slot == c_SW'(c_WORDS - 1))
      w_pad = w_pad | c_PAD_TAIL;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_IDLE;
      r_msg      <= '0;
      r_base     <= '0;
      r_slot     <= '0;
      r_rd_slot  <= '0;
      r_cap      <= 1'b0;
      r_cap_slot <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      blk_valid  <= 1'b0;
      blk_first  <= 1'b0;
      blk_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dout       <= '0;
    end else begin
      mem_rd_en  <= 1'b0;
      done       <= 1'b0;
      r_cap      <= mem_rd_en;
      r_cap_slot <= r_rd_slot;

      for (int k = 0; k < c_WORDS; k++) begin
        if (r_cap && (r_cap_slot == c_SW'(k)))
          blk_data[k*DIGIT +: DIGIT] <= mem_rdata;
        if (w_issue && !w_read && (w_slot == c_SW'(k)))
          blk_data[k*DIGIT +: DIGIT] <= w_pad;
      end

      if (w_issue) begin
        r_slot <= w_slot + c_SW'(1);
        if (w_read) begin
          mem_rd_en <= 1'b1;
          mem_addr  <= w_gidx[AW-1:0];
          r_rd_slot <= w_slot;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FILL;
            r_msg   <= msg_words;
            r_base  <= '0;
            busy    <= 1'b1;
          end
        end
        S_FILL: begin
          // The last outstanding read, if any, lands in blk_data on this edge.
          if ((r_slot == c_SW'(c_WORDS)) && !mem_rd_en) begin
            r_state   <= S_OFFER;
            blk_valid <= 1'b1;
            blk_first <= (r_base == '0);
          end
        end
        S_OFFER: begin
          if (blk_ready) begin
            r_state   <= S_PERM;
            blk_valid <= 1'b0;
            blk_first <= 1'b0;
          end
        end
        S_PERM: begin
          if (perm_done) begin
            if (w_more) begin
              r_state <= S_FILL;
              r_base  <= w_next_base;
            end else begin
              r_state <= S_DONE;
              done    <= 1'b1;
              busy    <= 1'b0;
              dout    <= state_out;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
